// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide controller: op codes, FSM states, default latencies.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MDU_none  = 3'd0,
        MDU_mult  = 3'd1,
        MDU_multu = 3'd2,
        MDU_div   = 3'd3,
        MDU_divu  = 3'd4,
        MDU_mthi  = 3'd5,
        MDU_mtlo  = 3'd6
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W_DEF       = 4;

    // True for the ops that occupy the unit for multiple cycles.
    function automatic logic is_md(input logic [2:0] o);
        return (o == MDU_mult) || (o == MDU_multu) || (o == MDU_div) || (o == MDU_divu);
    endfunction

    function automatic logic is_mult(input logic [2:0] o);
        return (o == MDU_mult) || (o == MDU_multu);
    endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational HI/LO result generator for mult/multu/div/divu; flags divide by zero.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; result valid whenever inputs are.
module mdu_calc
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] hi_res,
    output logic [31:0] lo_res,
    output logic        div0
);

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] bs;
    logic signed [31:0] qs;
    logic signed [31:0] rs;
    logic        [31:0] qu;
    logic        [31:0] ru;
    logic               ovf;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // A zero divisor is replaced so the dividers never see /0; the result is discarded anyway.
    assign bs  = (B == 32'd0) ? 32'd1 : B;
    assign qs  = $signed(A) / $signed(bs);
    assign rs  = $signed(A) % $signed(bs);
    assign qu  = A / bs;
    assign ru  = A % bs;
    assign ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    always_comb begin
        hi_res = '0;
        lo_res = '0;
        div0   = 1'b0;
        case (op)
            MDU_mult: begin
                hi_res = prod_s[63:32];
                lo_res = prod_s[31:0];
            end
            MDU_multu: begin
                hi_res = prod_u[63:32];
                lo_res = prod_u[31:0];
            end
            MDU_div: begin
                div0   = (B == 32'd0);
                hi_res = ovf ? 32'd0 : rs;
                lo_res = ovf ? A : qs;
            end
            MDU_divu: begin
                div0   = (B == 32'd0);
                hi_res = ru;
                lo_res = qu;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer owning HI/LO; models fixed MIPS mult/div latency.
// Latency: mthi/mtlo 1 edge; mult MULT_CYCLES busy, div DIV_CYCLES busy, result visible the cycle after.
// Backpressure: busy stalls md-type instructions upstream; start while busy is ignored.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    mdu_state_e       state_q;
    mdu_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [63:0]      pend_q;
    logic             pend_div0_q;

    logic             launch;
    logic             md_launch;
    logic             commit;
    logic [31:0]      hi_res;
    logic [31:0]      lo_res;
    logic             div0;

    mdu_calc u_calc (
        .op     (op),
        .A      (A),
        .B      (B),
        .hi_res (hi_res),
        .lo_res (lo_res),
        .div0   (div0)
    );

    assign busy      = (state_q == S_RUN);
    assign launch    = start & ~flush & ~busy & (op != MDU_none);
    assign md_launch = launch & is_md(op);
    assign commit    = (state_q == S_RUN) && (cnt_q == CNT_W'(1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (md_launch) state_d = S_RUN;
            S_RUN:   if (commit)    state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Flush only gates the launch; an operation already in RUN always completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_div0_q <= 1'b0;
            hi          <= '0;
            lo          <= '0;
        end else begin
            state_q <= state_d;
            if (md_launch) begin
                cnt_q       <= is_mult(op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                pend_q      <= {hi_res, lo_res};
                pend_div0_q <= div0;
            end else if (state_q == S_RUN) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            if (commit) begin
                if (!pend_div0_q) begin
                    hi <= pend_q[63:32];
                    lo <= pend_q[31:0];
                end
            end else if (launch && (op == MDU_mthi)) begin
                hi <= A;
            end else if (launch && (op == MDU_mtlo)) begin
                lo <= A;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed plus randomized bench for mdu_ctrl against an arithmetic reference model.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks;
    int          errors;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .flush (flush),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit integer arithmetic, truncating division, HI/LO unchanged on /0.
    function automatic logic [63:0] ref_md(input logic [2:0] o, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     q;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (o)
            MDU_mult:  return sa * sb;
            MDU_multu: return ua * ub;
            MDU_div: begin
                if (b == 32'd0) return cur;
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            MDU_divu: begin
                if (b == 32'd0) return cur;
                q = ua / ub;
                r = ua % ub;
                return {r[31:0], q[31:0]};
            end
            default: return cur;
        endcase
    endfunction

    // Launch at the current cycle, optionally flush in cycle flush_at of RUN and
    // issue an illegal start (protocol violation, must be ignored) in cycle spur_at.
    task automatic run_md(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int flush_at, input int spur_at);
        int          n;
        logic [63:0] nxt;
        n   = is_mult(o) ? MULT_N : DIV_N;
        nxt = ref_md(o, a, b, {exp_hi, exp_lo});
        chk("idle_before_launch", {31'd0, busy}, 32'd0);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; op = MDU_none; A = $urandom; B = $urandom;
        for (int c = 1; c <= n; c++) begin
            chk("busy_in_run", {31'd0, busy}, 32'd1);
            chk("hi_hold_in_run", hi, exp_hi);
            chk("lo_hold_in_run", lo, exp_lo);
            flush = (c == flush_at);
            if (c == spur_at) begin
                start = 1'b1;
                op    = 3'($urandom_range(1, 6));
                A     = $urandom;
                B     = $urandom;
            end
            @(negedge clk);
            start = 1'b0; flush = 1'b0; op = MDU_none;
        end
        exp_hi = nxt[63:32];
        exp_lo = nxt[31:0];
        chk("busy_after_commit", {31'd0, busy}, 32'd0);
        chk("hi_after_commit", hi, exp_hi);
        chk("lo_after_commit", lo, exp_lo);
    endtask

    task automatic run_mt(input logic [2:0] o, input logic [31:0] a);
        chk("idle_before_mt", {31'd0, busy}, 32'd0);
        start = 1'b1; op = o; A = a;
        @(negedge clk);
        start = 1'b0; op = MDU_none;
        if (o == MDU_mthi) exp_hi = a;
        else               exp_lo = a;
        chk("mt_busy", {31'd0, busy}, 32'd0);
        chk("mt_hi", hi, exp_hi);
        chk("mt_lo", lo, exp_lo);
    endtask

    // start and flush together: nothing may launch or write.
    task automatic run_flushed(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; flush = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; op = MDU_none;
        for (int c = 0; c < 3; c++) begin
            chk("flushed_busy", {31'd0, busy}, 32'd0);
            chk("flushed_hi", hi, exp_hi);
            chk("flushed_lo", lo, exp_lo);
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0; errors = 0;
        exp_hi = '0; exp_lo = '0;
        reset = 1'b1; start = 1'b0; flush = 1'b0; op = MDU_none; A = '0; B = '0;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_md(MDU_mult,  32'hFFFF_FFFE, 32'd3, 0, 0);
        chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", lo, 32'hFFFF_FFFA);
        run_md(MDU_multu, 32'hFFFF_FFFF, 32'd2, 0, 0);
        chk("multu_hi", hi, 32'h0000_0001);
        chk("multu_lo", lo, 32'hFFFF_FFFE);
        run_md(MDU_div,   32'hFFFF_FFF9, 32'd2, 0, 0);
        chk("div_neg_lo", lo, 32'hFFFF_FFFD);
        chk("div_neg_hi", hi, 32'hFFFF_FFFF);
        run_md(MDU_divu,  32'd7, 32'd0, 0, 0);
        chk("divu_zero_lo", lo, 32'hFFFF_FFFD);
        run_mt(MDU_mthi, 32'h1234_5678);
        run_mt(MDU_mtlo, 32'h9ABC_DEF0);
        run_flushed(MDU_div, 32'd100, 32'd7);
        run_md(MDU_mult,  32'd1000, 32'd1000, 3, 0);
        run_md(MDU_divu,  32'd1000, 32'd7, 0, 4);
        run_md(MDU_div,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("div_ovf_lo", lo, 32'h8000_0000);
        chk("div_ovf_hi", hi, 32'd0);
        run_mt(MDU_mthi, 32'hCAFE_F00D);

        // Async reset mid-RUN: outputs clear between clock edges and no commit follows.
        start = 1'b1; op = MDU_div; A = 32'd99; B = 32'd4;
        @(negedge clk);
        start = 1'b0; op = MDU_none;
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        exp_hi = '0; exp_lo = '0;
        chk("async_reset_busy", {31'd0, busy}, 32'd0);
        chk("async_reset_hi", hi, 32'd0);
        chk("async_reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < DIV_N + 2; c++) begin
            chk("post_reset_busy", {31'd0, busy}, 32'd0);
            chk("post_reset_hi", hi, exp_hi);
            chk("post_reset_lo", lo, exp_lo);
            @(negedge clk);
        end

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            ro = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 7) == 0) begin
                run_flushed(ro, ra, rb);
            end else if (is_md(ro)) begin
                run_md(ro, ra, rb, int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
            end else begin
                run_mt(ro, ra);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide controller for the EX stage, alongside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo issued from EX and owns the HI/LO registers.
- Drives a busy flag that hazard logic uses to stall md-type instructions in ID.
- Models MIPS timing: 5-cycle multiply, 10-cycle divide. Honours the pipeline flush on exception/interrupt.

Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (>=1)
- DIV_CYCLES, 10, busy duration for div/divu (>=1)
- CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  EX stage holds a valid md instruction this cycle
- op  in  3  operation: MDU_none, MDU_mult, MDU_multu, MDU_div, MDU_divu, MDU_mthi, MDU_mtlo
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- flush  in  1  EX instruction is being cancelled (exception/interrupt request)
- busy  out  1  multi-cycle operation in flight
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (async, immediate): hi=0, lo=0, busy=0, counter=0, pending result=0, state IDLE.
- Launch condition: launch = start & ~flush & ~busy & op != MDU_none.
- FSM states: IDLE, RUN.
- IDLE, launch with mult/multu/div/divu:
  - Latch A, B and op.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN. busy=1 from the next cycle.
- IDLE, launch with mthi/mtlo: hi<=A (or lo<=A) at this edge; stay IDLE; busy stays 0.
- RUN:
  - Counter decrements each cycle.
  - On the edge where counter==1: write HI/LO from the pending result, busy<=0, go to IDLE.
  - busy is high for exactly N cycles. New hi/lo are visible in cycle N+1 after the start cycle.
- Arithmetic (from latched operands):
  - mult: signed 64-bit product, hi=[63:32], lo=[31:0].
  - multu: same, unsigned.
  - div: lo=signed quotient, hi=signed remainder. Remainder sign follows the dividend (truncating division).
  - divu: lo=unsigned quotient, hi=unsigned remainder.
  - Compute combinationally at launch into a 64-bit pending register, or at commit from latched operands; visible behaviour is identical.
- Divide by zero (B==0 at launch): full DIV_CYCLES busy; HI/LO left unchanged at commit.
- Overflow case, div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- start while busy=1: ignored. Upstream stalls such instructions; the bench flags it as a protocol violation.
- mthi/mtlo while busy: ignored (stalled upstream).
- flush with start in the same cycle: nothing launched, no HI/LO write.
- flush while RUN: no effect. The in-flight operation completes and commits, as on MIPS where the operation already left EX.
- Reset asserted mid-RUN: aborts immediately to the reset state; no commit.
- Back-to-back: a new start may launch in the first cycle busy==0, including the cycle right after commit. Launch reads operands only; it does not read hi/lo.
- hi/lo are plain register outputs with no bypass. mfhi/mflo in EX see committed values; hazard logic stalls mfhi/mflo while start|busy.

Decomposition:
- Shared header: op codes MDU_none=3'd0, MDU_mult=1, MDU_multu=2, MDU_div=3, MDU_divu=4, MDU_mthi=5, MDU_mtlo=6; state codes; default latencies.
- Optional sub-module mdu_calc: combinational, (op, A, B) -> {hi_res, lo_res, div0}. Keeps the sequencer FSM separate from the arithmetic.

Test Plan:
- mult A=0xFFFFFFFE (-2), B=3 at cycle 0 -> busy high cycles 1..5; cycle 6 hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu A=0xFFFFFFFF, B=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu A=7, B=0 -> busy 10 cycles, hi/lo unchanged.
- mthi A=0x12345678, then next cycle mtlo A=0x9ABCDEF0 -> hi/lo updated one edge after each; busy never asserted.
- start+flush same cycle with div -> busy stays 0, hi/lo unchanged. Flush during cycle 3 of mult -> still commits at cycle 6.
- Async reset pulse mid-RUN of div (cycle 4) -> busy, hi, lo go 0 immediately without a clock edge; no later commit. Start during busy -> ignored, original result committed.
